// File: rtl/apb_reg_bank.sv
// apb_reg_bank: APB slave holding NUM_REGS read/write registers plus a
// read-only STATUS word, with a start/busy/done handshake to a downstream core.
// Writing CTRL (register 0) launches the core. Writes are refused while it runs.
// Optional build macro APB_SLVERR_EN: report PSLVERR on erroneous transfers.
module apb_reg_bank #(
  parameter int AMBA_WORD       = 32,
  parameter int AMBA_ADDR_WIDTH = 20,
  parameter int NUM_REGS        = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          PSEL,
  input  logic                          PENABLE,
  input  logic                          PWRITE,
  input  logic [AMBA_ADDR_WIDTH-1:0]    PADDR,
  input  logic [AMBA_WORD-1:0]          PWDATA,
  output logic [AMBA_WORD-1:0]          PRDATA,
  output logic                          PREADY,
  output logic                          PSLVERR,
  input  logic                          done,
  output logic [NUM_REGS*AMBA_WORD-1:0] regs,
  output logic                          start,
  output logic                          busy
);

  // state  | meaning
  // IDLE   | no transfer in progress
  // SETUP  | address phase seen, waiting for PENABLE
  // ACCESS | PREADY high, transfer completes at the next edge
  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2} state_t;

  localparam int WIDX_W = AMBA_ADDR_WIDTH - 2;

  state_t                     state_q, state_d;
  logic [AMBA_WORD-1:0]       regs_q [NUM_REGS];
  logic [AMBA_WORD-1:0]       regs_d [NUM_REGS];
  logic [AMBA_WORD-1:0]       prdata_q, prdata_d, wdata_q, wdata_d;
  logic [AMBA_WORD-1:0]       rd_val, status_val;
  logic [AMBA_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                       wr_q, wr_d, blk_q, blk_d;
  logic                       pready_q, pready_d, start_q, start_d;
  logic                       busy_q, busy_d, sticky_q, sticky_d;
  logic [WIDX_W-1:0]          live_idx, acc_idx;
  logic                       live_reg, live_status, acc_reg, acc_status;
  logic                       setup_done, wr_commit, ctrl_wr, status_rd;

  // Address decode of the live bus (read/error) and of the captured address (commit).
  always_comb begin
    live_idx    = PADDR[AMBA_ADDR_WIDTH-1:2];
    live_reg    = (PADDR[1:0] == 2'b00) && (live_idx < WIDX_W'(NUM_REGS));
    live_status = (PADDR[1:0] == 2'b00) && (live_idx == WIDX_W'(NUM_REGS));
    acc_idx     = addr_q[AMBA_ADDR_WIDTH-1:2];
    acc_reg     = (addr_q[1:0] == 2'b00) && (acc_idx < WIDX_W'(NUM_REGS));
    acc_status  = (addr_q[1:0] == 2'b00) && (acc_idx == WIDX_W'(NUM_REGS));
    status_val    = '0;
    status_val[0] = sticky_q;
    status_val[1] = busy_q;
    rd_val = live_status ? status_val : '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (live_reg && (live_idx == WIDX_W'(i))) rd_val = regs_q[i];
  end

  // Bus FSM next state; PENABLE seen in IDLE is ignored.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (PSEL && !PENABLE) state_d = SETUP;
      SETUP:   if (!PSEL) state_d = IDLE;
               else if (PENABLE) state_d = ACCESS;
      ACCESS:  state_d = (PSEL && !PENABLE) ? SETUP : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Transfer is captured when SETUP completes, so the commit at the end of
  // ACCESS is unaffected by a back-to-back master already driving the next address.
  always_comb begin
    setup_done = (state_q == SETUP) && PSEL && PENABLE;
    addr_d     = setup_done ? PADDR   : addr_q;
    wr_d       = setup_done ? PWRITE  : wr_q;
    wdata_d    = setup_done ? PWDATA  : wdata_q;
    blk_d      = setup_done ? busy_q  : blk_q;
    prdata_d   = setup_done ? rd_val  : prdata_q;
    pready_d   = (state_d == ACCESS);
    wr_commit  = (state_q == ACCESS) && wr_q && acc_reg && !blk_q;
    ctrl_wr    = wr_commit && (acc_idx == '0);
    status_rd  = (state_q == ACCESS) && !wr_q && acc_status;
    start_d    = ctrl_wr;
    busy_d     = ctrl_wr ? 1'b1 : (done ? 1'b0 : busy_q);
    sticky_d   = done ? 1'b1 : (status_rd ? 1'b0 : sticky_q);
    regs_d     = regs_q;
    for (int i = 0; i < NUM_REGS; i++)
      if (wr_commit && (acc_idx == WIDX_W'(i))) regs_d[i] = wdata_q;
  end

  // All state and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wr_q     <= 1'b0;
      wdata_q  <= '0;
      blk_q    <= 1'b0;
      prdata_q <= '0;
      pready_q <= 1'b0;
      start_q  <= 1'b0;
      busy_q   <= 1'b0;
      sticky_q <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wr_q     <= wr_d;
      wdata_q  <= wdata_d;
      blk_q    <= blk_d;
      prdata_q <= prdata_d;
      pready_q <= pready_d;
      start_q  <= start_d;
      busy_q   <= busy_d;
      sticky_q <= sticky_d;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
    end
  end

`ifdef APB_SLVERR_EN
  logic slverr_q, slverr_d;

  // Error flag is captured with the address phase so it lines up with PREADY.
  always_comb begin
    slverr_d = 1'b0;
    if (setup_done)
      slverr_d = !(live_reg || live_status) || (PWRITE && live_status) ||
                 (PWRITE && live_reg && busy_q);
  end

  // Error flag register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) slverr_q <= 1'b0;
    else      slverr_q <= slverr_d;
  end

  assign PSLVERR = slverr_q;
`else
  assign PSLVERR = 1'b0;
`endif

  assign PRDATA = prdata_q;
  assign PREADY = pready_q;
  assign start  = start_q;
  assign busy   = busy_q;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs
    assign regs[g*AMBA_WORD +: AMBA_WORD] = regs_q[g];
  end

endmodule

// File: tb/tb_apb_reg_bank.sv
// Self-checking bench for apb_reg_bank against a word-level register model.
module tb_apb_reg_bank;
  localparam int W  = 32;
  localparam int AW = 20;
  localparam int N  = 4;
`ifdef APB_SLVERR_EN
  localparam bit SLV = 1'b1;
`else
  localparam bit SLV = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [AW-1:0] PADDR = '0;
  logic [W-1:0]  PWDATA = '0;
  logic [W-1:0]  PRDATA;
  logic          PREADY, PSLVERR;
  logic          done = 1'b0;
  logic [N*W-1:0] regs;
  logic          start, busy;

  apb_reg_bank #(.AMBA_WORD(W), .AMBA_ADDR_WIDTH(AW), .NUM_REGS(N)) dut (
    .clk(clk), .rst(rst), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR), .done(done), .regs(regs), .start(start), .busy(busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int start_cnt = 0;

  always @(negedge clk) if (start === 1'b1) start_cnt++;

  // reference model
  logic [W-1:0] m_regs [N];
  bit m_busy, m_sticky;
  int exp_start = 0;

  function automatic int m_kind(input logic [AW-1:0] a);
    int idx;
    if (a % 4 != 0) return 2;
    idx = int'(a / 4);
    if (idx < N) return 0;
    if (idx == N) return 1;
    return 2;
  endfunction

  function automatic logic [W-1:0] m_rd(input logic [AW-1:0] a);
    case (m_kind(a))
      0: return m_regs[a / 4];
      1: return W'(m_busy) * 2 + W'(m_sticky);
      default: return '0;
    endcase
  endfunction

  function automatic bit m_err(input logic [AW-1:0] a, input bit wr);
    int k;
    k = m_kind(a);
    if (!SLV) return 1'b0;
    return (k == 2) || (wr && k == 1) || (wr && k == 0 && m_busy);
  endfunction

  function automatic logic [N*W-1:0] m_vec();
    logic [N*W-1:0] v;
    for (int i = 0; i < N; i++) v[i*W +: W] = m_regs[i];
    return v;
  endfunction

  task automatic m_commit(input logic [AW-1:0] a, input bit wr, input logic [W-1:0] d);
    int k;
    k = m_kind(a);
    if (wr && k == 0 && !m_busy) begin
      m_regs[a / 4] = d;
      if (a / 4 == 0) begin
        m_busy = 1'b1;
        exp_start++;
      end
    end
    if (!wr && k == 1) m_sticky = 1'b0;
  endtask

  task automatic m_reset();
    for (int i = 0; i < N; i++) m_regs[i] = '0;
    m_busy = 1'b0;
    m_sticky = 1'b0;
  endtask

  // Bus driver: starts and ends on a falling edge.
  task automatic apb_xfer(input logic [AW-1:0] a, input bit wr, input logic [W-1:0] d,
                          input bit chain, output logic [W-1:0] rdata,
                          output logic err, output int waits);
    PSEL = 1'b1; PENABLE = 1'b0; PADDR = a; PWRITE = wr; PWDATA = d;
    @(negedge clk);
    PENABLE = 1'b1;
    waits = 0;
    do begin
      @(negedge clk);
      waits++;
    end while (PREADY !== 1'b1 && waits < 8);
    rdata = PRDATA;
    err = PSLVERR;
    if (!chain) begin
      PSEL = 1'b0; PENABLE = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic pulse_done();
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    m_busy = 1'b0;
    m_sticky = 1'b1;
  endtask

  task automatic test_reset();
    m_reset();
    repeat (2) @(negedge clk);
    tests++;
    if ({PRDATA, PREADY, PSLVERR, start, busy} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got prdata=%h pready=%b slverr=%b start=%b busy=%b, want all 0",
               PRDATA, PREADY, PSLVERR, start, busy);
    end
    tests++;
    if (regs !== m_vec()) begin
      fails++;
      $display("FAIL reset_regs: got %h want %h", regs, m_vec());
    end
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if (PREADY !== 1'b0) begin
      fails++;
      $display("FAIL idle_pready: got %b want 0", PREADY);
    end
  endtask

  task automatic test_rw();
    logic [W-1:0] rd; logic er; int wt;
    apb_xfer(20'h4, 1'b1, 32'hDEADBEEF, 1'b0, rd, er, wt);
    m_commit(20'h4, 1'b1, 32'hDEADBEEF);
    apb_xfer(20'h4, 1'b0, '0, 1'b0, rd, er, wt);
    tests++;
    if (rd !== 32'hDEADBEEF || wt != 1) begin
      fails++;
      $display("FAIL rw_read: got %h after %0d waits, want deadbeef after 1", rd, wt);
    end
    tests++;
    if (regs[63:32] !== 32'hDEADBEEF || regs !== m_vec()) begin
      fails++;
      $display("FAIL rw_regs: got %h want %h", regs, m_vec());
    end
    tests++;
    if (start_cnt != 0) begin
      fails++;
      $display("FAIL rw_no_start: got %0d pulses want 0", start_cnt);
    end
  endtask

  task automatic test_ctrl_done();
    logic [W-1:0] rd; logic er; int wt;
    apb_xfer(20'h0, 1'b1, 32'h1, 1'b0, rd, er, wt);
    m_commit(20'h0, 1'b1, 32'h1);
    tests++;
    if (start !== 1'b1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL ctrl_start: got start=%b busy=%b want 1 1", start, busy);
    end
    @(negedge clk);
    tests++;
    if (start !== 1'b0 || start_cnt != exp_start) begin
      fails++;
      $display("FAIL ctrl_start_width: got start=%b pulses=%0d want 0 %0d", start, start_cnt, exp_start);
    end
    pulse_done();
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL done_busy: got %b want 0", busy);
    end
    for (int k = 0; k < 2; k++) begin
      logic [W-1:0] exp;
      exp = m_rd(20'h10);
      apb_xfer(20'h10, 1'b0, '0, 1'b0, rd, er, wt);
      m_commit(20'h10, 1'b0, '0);
      tests++;
      if (rd !== exp || exp !== ((k == 0) ? 32'h1 : 32'h0)) begin
        fails++;
        $display("FAIL status_read%0d: got %h want %h", k, rd, exp);
      end
    end
  endtask

  task automatic test_busy_discard();
    logic [W-1:0] rd; logic er; int wt; bit exp_er;
    apb_xfer(20'h8, 1'b1, 32'h1234, 1'b0, rd, er, wt);
    m_commit(20'h8, 1'b1, 32'h1234);
    apb_xfer(20'h0, 1'b1, 32'h3, 1'b0, rd, er, wt);
    m_commit(20'h0, 1'b1, 32'h3);
    exp_er = m_err(20'h8, 1'b1);
    apb_xfer(20'h8, 1'b1, 32'h55, 1'b0, rd, er, wt);
    m_commit(20'h8, 1'b1, 32'h55);
    tests++;
    if (er !== exp_er) begin
      fails++;
      $display("FAIL busy_slverr: got %b want %b", er, exp_er);
    end
    tests++;
    if (regs[95:64] !== 32'h1234 || regs !== m_vec()) begin
      fails++;
      $display("FAIL busy_discard: got %h want %h", regs, m_vec());
    end
    exp_er = m_err(20'h0, 1'b1);
    apb_xfer(20'h0, 1'b1, 32'h7, 1'b0, rd, er, wt);
    m_commit(20'h0, 1'b1, 32'h7);
    repeat (2) @(negedge clk);
    tests++;
    if (start_cnt != exp_start || er !== exp_er || regs !== m_vec()) begin
      fails++;
      $display("FAIL busy_ctrl: got pulses=%0d err=%b regs=%h want %0d %b %h",
               start_cnt, er, regs, exp_start, exp_er, m_vec());
    end
    pulse_done();
  endtask

  task automatic test_unmapped();
    logic [W-1:0] rd; logic er; int wt;
    logic [AW-1:0] addrs [2];
    addrs[0] = 20'h40;
    addrs[1] = 20'h5;
    foreach (addrs[k]) begin
      apb_xfer(addrs[k], 1'b0, '0, 1'b0, rd, er, wt);
      tests++;
      if (rd !== '0 || er !== SLV) begin
        fails++;
        $display("FAIL unmapped_%h: got data=%h err=%b want 0 %b", addrs[k], rd, er, SLV);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] rd; logic er; int wt1, wt2;
    apb_xfer(20'h4, 1'b1, 32'hA, 1'b1, rd, er, wt1);
    m_commit(20'h4, 1'b1, 32'hA);
    apb_xfer(20'h4, 1'b0, '0, 1'b0, rd, er, wt2);
    tests++;
    if (rd !== 32'hA || wt1 != 1 || wt2 != 1) begin
      fails++;
      $display("FAIL b2b: got data=%h waits=%0d/%0d want 0000000a waits 1/1", rd, wt1, wt2);
    end
  endtask

  task automatic test_protocol();
    PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = 20'h4; PWDATA = 32'hFFFF_FFFF;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tests++;
      if (PREADY !== 1'b0) begin
        fails++;
        $display("FAIL protocol_pready%0d: got %b want 0", k, PREADY);
      end
    end
    PSEL = 1'b0; PENABLE = 1'b0;
    @(negedge clk);
    tests++;
    if (regs !== m_vec()) begin
      fails++;
      $display("FAIL protocol_regs: got %h want %h", regs, m_vec());
    end
  endtask

  task automatic test_random();
    logic [W-1:0] rd, exp_rd; logic er; int wt;
    logic [AW-1:0] a; bit wr, ch, exp_er; logic [W-1:0] d;
    int bad = 0;
    for (int it = 0; it < 150; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: a = AW'(4 * $urandom_range(0, N));
        6: a = AW'(4 * $urandom_range(0, N) + $urandom_range(1, 3));
        7: a = AW'(4 * $urandom_range(N + 1, 64));
        8: a = AW'($urandom_range(1, 15) * 4096);
        default: a = 20'h0;
      endcase
      wr = $urandom_range(0, 1) == 1;
      d = $urandom;
      ch = ($urandom_range(0, 3) == 0) && (it != 149);
      exp_rd = m_rd(a);
      exp_er = m_err(a, wr);
      apb_xfer(a, wr, d, ch, rd, er, wt);
      m_commit(a, wr, d);
      tests++;
      if (wt != 1 || er !== exp_er || (!wr && rd !== exp_rd)) begin
        fails++; bad++;
        $display("FAIL rand%0d addr=%h wr=%b: got data=%h err=%b waits=%0d want %h %b 1",
                 it, a, wr, rd, er, wt, exp_rd, exp_er);
      end
      if (!ch) begin
        tests++;
        if (regs !== m_vec() || busy !== m_busy) begin
          fails++;
          $display("FAIL rand%0d_state: got regs=%h busy=%b want %h %b", it, regs, busy, m_vec(), m_busy);
        end
        if ($urandom_range(0, 4) == 0) pulse_done();
      end
    end
    repeat (2) @(negedge clk);
    tests++;
    if (start_cnt != exp_start) begin
      fails++;
      $display("FAIL rand_starts: got %0d want %0d", start_cnt, exp_start);
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] rd; logic er; int wt;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 20'h4; PWDATA = 32'h77;
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    m_reset();
    tests++;
    if ({PRDATA, PREADY, PSLVERR, start, busy} !== '0 || regs !== m_vec()) begin
      fails++;
      $display("FAIL midreset_outputs: got prdata=%h pready=%b slverr=%b start=%b busy=%b regs=%h, want 0",
               PRDATA, PREADY, PSLVERR, start, busy, regs);
    end
    @(negedge clk);
    PENABLE = 1'b1;
    @(negedge clk);
    PSEL = 1'b0; PENABLE = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    apb_xfer(20'h4, 1'b0, '0, 1'b0, rd, er, wt);
    tests++;
    if (rd !== '0 || wt != 1 || regs !== m_vec()) begin
      fails++;
      $display("FAIL midreset_read: got %h waits=%0d regs=%h want 0 waits 1", rd, wt, regs);
    end
  endtask

  initial begin
    test_reset();
    test_rw();
    test_ctrl_done();
    test_busy_discard();
    test_unmapped();
    test_back_to_back();
    test_protocol();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/apb_reg_bank.md
APB_REG_BANK -- requirements
Module: apb_reg_bank

Interface
REQ-001 Parameter AMBA_WORD, default 32, SHALL set data bus and register width.
REQ-002 Parameter AMBA_ADDR_WIDTH, default 20, SHALL set PADDR width.
REQ-003 Parameter NUM_REGS, default 4, legal 2..15, SHALL set the number of read/write registers.
REQ-004 Port clk, input, 1 bit: the single clock; all flops on its rising edge.
REQ-005 Port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-006 Port PSEL, input, 1 bit: APB select.
REQ-007 Port PENABLE, input, 1 bit: APB enable.
REQ-008 Port PWRITE, input, 1 bit: 1 = write, 0 = read.
REQ-009 Port PADDR, input, AMBA_ADDR_WIDTH bits: byte address.
REQ-010 Port PWDATA, input, AMBA_WORD bits: write data.
REQ-011 Port PRDATA, output, AMBA_WORD bits: read data.
REQ-012 Port PREADY, output, 1 bit: transfer complete.
REQ-013 Port PSLVERR, output, 1 bit: transfer error; valid only while PREADY=1.
REQ-014 Port done, input, 1 bit: single-cycle completion pulse from the downstream core.
REQ-015 Port regs, output, NUM_REGS*AMBA_WORD bits: register i on bits [i*AMBA_WORD +: AMBA_WORD].
REQ-016 Port start, output, 1 bit: single-cycle pulse to the downstream core.
REQ-017 Port busy, output, 1 bit: the core is running.

Function
REQ-018 Register i SHALL decode at byte offset 4*i. Register 0 is CTRL. A read-only STATUS register SHALL decode at offset 4*NUM_REGS: bit0 = done_sticky, bit1 = busy, all other bits 0.
REQ-019 The FSM SHALL have states IDLE, SETUP and ACCESS.
- IDLE -> SETUP on PSEL & !PENABLE.
- SETUP -> ACCESS on PSEL & PENABLE; SETUP -> IDLE on !PSEL.
- ACCESS -> SETUP on PSEL & !PENABLE (back-to-back transfer); ACCESS -> IDLE otherwise.
REQ-020 PREADY SHALL be 1 in ACCESS and 0 in every other state (exactly one wait-free access cycle).
REQ-021 PRDATA SHALL be registered at the end of SETUP from the addressed register, hold through ACCESS, and hold otherwise. Unmapped addresses SHALL read 0.
REQ-022 A write SHALL update the addressed register at the clock edge ending ACCESS. The new value SHALL be visible on regs the following cycle.
REQ-023 A successful write to CTRL SHALL pulse start high for exactly one cycle, on the cycle after the write edge. busy SHALL set on that same edge.
REQ-024 done=1 SHALL clear busy and set done_sticky on the next edge.
REQ-025 A completed read of STATUS SHALL clear done_sticky. If done and the STATUS read occur on the same edge, done_sticky SHALL remain 1.
REQ-026 If a start pulse and done coincide, busy SHALL remain 1.
REQ-027 While busy=1, writes to registers 0..NUM_REGS-1 SHALL be discarded and SHALL NOT generate start. Reads SHALL be unaffected.
REQ-028 Writes to STATUS or to unmapped offsets SHALL be discarded.
REQ-029 PADDR[1:0] != 0 SHALL be treated as unmapped.
REQ-030 PENABLE=1 observed in IDLE is a protocol violation: the FSM SHALL stay in IDLE and no register SHALL change.

Reset
REQ-031 While rst=0, asynchronously and independent of clk:
- FSM = IDLE;
- all registers = 0;
- PRDATA = 0; PREADY = 0; PSLVERR = 0;
- start = 0; busy = 0; done_sticky = 0.
REQ-032 rst asserted mid-transfer SHALL abort the transfer with no register update. The first transfer after rst rises SHALL begin from IDLE.

Configuration
REQ-033 With macro APB_SLVERR_EN defined, PSLVERR SHALL be 1 in ACCESS for each of the following, and 0 otherwise:
- unmapped address;
- misaligned address;
- write to STATUS;
- write discarded because busy=1.
REQ-034 Without APB_SLVERR_EN, PSLVERR SHALL be tied to 0. Discard behaviour is unchanged.

Verification
REQ-035 Reset release, write 0xDEADBEEF to offset 0x4, read offset 0x4 -> PRDATA=0xDEADBEEF in ACCESS; regs[63:32]=0xDEADBEEF; start never pulses.
REQ-036 Write 0x1 to CTRL -> start high exactly one cycle after the write edge; busy=1. Pulse done -> busy=0; STATUS read returns 0x1, then a second STATUS read returns 0x0.
REQ-037 While busy=1, write 0x55 to offset 0x8 -> register 2 keeps its old value; no start; PSLVERR=1 with APB_SLVERR_EN and 0 without.
REQ-038 Read offset 0x40 and read offset 0x5 -> PRDATA=0; PSLVERR=1 with APB_SLVERR_EN.
REQ-039 Back-to-back write 0xA to 0x4 then read 0x4 with no IDLE between -> FSM goes ACCESS -> SETUP -> ACCESS; read returns 0xA.
REQ-040 Drive rst=0 during SETUP of a write of 0x77 to 0x4 -> all outputs 0 immediately; after release, reading 0x4 returns 0.
